// File: rtl/mc_pkg.sv
// mc_pkg: shared encodings for the multicycle MIPS sequencing controller.
//   - mc_state_e : 4-bit FSM state encoding
//   - opcode/funct constants for the supported instructions
//   - AluOP, ALUSrcB and PCSource select encodings
//   - mc_ctrl_t  : bundle of every datapath control driven by the controller
// Optional feature macro: MC_JAL_JR_EN (enables the JAL and JR paths).
package mc_pkg;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_FETCH  = 4'd1,
    ST_DECODE = 4'd2,
    ST_MEMADR = 4'd3,
    ST_MEMRD  = 4'd4,
    ST_MEMWB  = 4'd5,
    ST_MEMWR  = 4'd6,
    ST_EXEC   = 4'd7,
    ST_RWB    = 4'd8,
    ST_BRANCH = 4'd9,
    ST_JUMP   = 4'd10,
    ST_JAL    = 4'd11,
    ST_JR     = 4'd12,
    ST_TRAP   = 4'd13
  } mc_state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] FUNCT_JR = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_RS     = 2'b11;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic       jal;
    logic [1:0] pc_source;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       instr_done;
    logic       illegal;
  } mc_ctrl_t;

  // Loads and stores share the address-calculation cycle.
  function automatic logic is_mem_op(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/mc_out_decode.sv
// mc_out_decode: purely combinational map from controller state (plus
// mem_ready) to the full set of datapath controls. Every control defaults
// to 0, so states that do not mention a control never drive X.
// Ports:
//   state_i      in  current FSM state
//   mem_ready_i  in  memory handshake; qualifies IRWrite/PCWrite in FETCH
//                    and instr_done in MEMWR
//   ctrl_o       out bundled datapath controls
// Optional feature macro: MC_JAL_JR_EN (JAL/JR output patterns).
module mc_out_decode
  import mc_pkg::*;
(
  input  mc_state_e state_i,
  input  logic      mem_ready_i,
  output mc_ctrl_t  ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (state_i)
      ST_FETCH: begin
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.alu_src_b = SRCB_FOUR;
        ctrl_o.alu_op    = ALUOP_ADD;
        ctrl_o.pc_source = PCSRC_ALU;
        // PC+4 and the IR latch only once the instruction word has arrived.
        ctrl_o.ir_write  = mem_ready_i;
        ctrl_o.pc_write  = mem_ready_i;
      end
      ST_DECODE: begin
        // Speculative branch target: PC + (imm << 2).
        ctrl_o.alu_src_b = SRCB_IMMSH;
        ctrl_o.alu_op    = ALUOP_ADD;
      end
      ST_MEMADR: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = ALUOP_ADD;
      end
      ST_MEMRD: begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.i_or_d   = 1'b1;
      end
      ST_MEMWB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      ST_MEMWR: begin
        ctrl_o.mem_write  = 1'b1;
        ctrl_o.i_or_d     = 1'b1;
        ctrl_o.instr_done = mem_ready_i;
      end
      ST_EXEC: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_B;
        ctrl_o.alu_op    = ALUOP_FUNCT;
      end
      ST_RWB: begin
        ctrl_o.reg_dst    = 1'b1;
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      ST_BRANCH: begin
        ctrl_o.alu_src_a     = 1'b1;
        ctrl_o.alu_src_b     = SRCB_B;
        ctrl_o.alu_op        = ALUOP_SUB;
        ctrl_o.pc_write_cond = 1'b1;
        ctrl_o.pc_source     = PCSRC_ALUOUT;
        ctrl_o.instr_done    = 1'b1;
      end
      ST_JUMP: begin
        ctrl_o.pc_write   = 1'b1;
        ctrl_o.pc_source  = PCSRC_JUMP;
        ctrl_o.instr_done = 1'b1;
      end
`ifdef MC_JAL_JR_EN
      ST_JAL: begin
        // Datapath routes PC to $31 when jal is high.
        ctrl_o.pc_write   = 1'b1;
        ctrl_o.pc_source  = PCSRC_JUMP;
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.jal        = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      ST_JR: begin
        ctrl_o.pc_write   = 1'b1;
        ctrl_o.pc_source  = PCSRC_RS;
        ctrl_o.instr_done = 1'b1;
      end
`endif
      ST_TRAP: begin
        ctrl_o.illegal = 1'b1;
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: Moore sequencing controller for the multicycle MIPS
// datapath. Holds the state register and next-state logic; the per-state
// output map lives in mc_out_decode.
// Ports:
//   clk_i, rst_i         clock, asynchronous active-high reset
//   opcode_i, funct_i    IR[31:26] / IR[5:0], valid from DECODE onward
//   mem_ready_i          memory completes the current access this cycle
//   *_o (1-bit)          PCWrite, PCWriteCond, IorD, MemRead, MemWrite,
//                        IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA, Jal
//   PCSource_o, ALUSrcB_o, AluOP_o   2-bit mux/ALU selects
//   instr_done_o         pulse in the last cycle of each instruction
//   illegal_o            sticky unsupported-instruction flag
// Optional feature macro: MC_JAL_JR_EN (adds jal and jr; otherwise both
// decode to TRAP).
//
// state  | meaning
// IDLE   | post-reset, goes to FETCH
// FETCH  | read instruction at PC, PC+4 (waits on mem_ready)
// DECODE | register read, branch target calc, dispatch on opcode
// MEMADR | lw/sw effective address
// MEMRD  | data read (waits on mem_ready)
// MEMWB  | write loaded data to rt
// MEMWR  | data write (waits on mem_ready)
// EXEC   | R-type ALU operation
// RWB    | write ALU result to rd
// BRANCH | beq compare and conditional PC update
// JUMP   | j target to PC
// JAL    | jal target to PC, PC to $31
// JR     | rs to PC
// TRAP   | unsupported instruction, held until reset
module multicycle_control
  import mc_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  input  logic       mem_ready_i,
  output logic       PCWrite_o,
  output logic       PCWriteCond_o,
  output logic       IorD_o,
  output logic       MemRead_o,
  output logic       MemWrite_o,
  output logic       IRWrite_o,
  output logic       MemtoReg_o,
  output logic       RegDst_o,
  output logic       RegWrite_o,
  output logic       ALUSrcA_o,
  output logic       Jal_o,
  output logic [1:0] PCSource_o,
  output logic [1:0] ALUSrcB_o,
  output logic [1:0] AluOP_o,
  output logic       instr_done_o,
  output logic       illegal_o
);

  mc_state_e state_q, state_d;
  mc_state_e decode_target;
  mc_ctrl_t  ctrl;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Dispatch target out of DECODE.
  always_comb begin
    decode_target = ST_TRAP;
    if (is_mem_op(opcode_i)) begin
      decode_target = ST_MEMADR;
    end else begin
      case (opcode_i)
        OP_RTYPE: begin
`ifdef MC_JAL_JR_EN
          decode_target = (funct_i == FUNCT_JR) ? ST_JR : ST_EXEC;
`else
          decode_target = (funct_i == FUNCT_JR) ? ST_TRAP : ST_EXEC;
`endif
        end
        OP_BEQ: decode_target = ST_BRANCH;
        OP_J:   decode_target = ST_JUMP;
`ifdef MC_JAL_JR_EN
        OP_JAL: decode_target = ST_JAL;
`endif
        default: decode_target = ST_TRAP;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   state_d = ST_FETCH;
      ST_FETCH:  if (mem_ready_i) state_d = ST_DECODE;
      ST_DECODE: state_d = decode_target;
      ST_MEMADR: state_d = (opcode_i == OP_LW) ? ST_MEMRD : ST_MEMWR;
      ST_MEMRD:  if (mem_ready_i) state_d = ST_MEMWB;
      ST_MEMWB:  state_d = ST_FETCH;
      ST_MEMWR:  if (mem_ready_i) state_d = ST_FETCH;
      ST_EXEC:   state_d = ST_RWB;
      ST_RWB:    state_d = ST_FETCH;
      ST_BRANCH: state_d = ST_FETCH;
      ST_JUMP:   state_d = ST_FETCH;
`ifdef MC_JAL_JR_EN
      ST_JAL:    state_d = ST_FETCH;
      ST_JR:     state_d = ST_FETCH;
`endif
      ST_TRAP:   state_d = ST_TRAP;
      // Unused encodings recover through IDLE.
      default:   state_d = ST_IDLE;
    endcase
  end

  mc_out_decode u_out_decode (
    .state_i     (state_q),
    .mem_ready_i (mem_ready_i),
    .ctrl_o      (ctrl)
  );

  assign PCWrite_o     = ctrl.pc_write;
  assign PCWriteCond_o = ctrl.pc_write_cond;
  assign IorD_o        = ctrl.i_or_d;
  assign MemRead_o     = ctrl.mem_read;
  assign MemWrite_o    = ctrl.mem_write;
  assign IRWrite_o     = ctrl.ir_write;
  assign MemtoReg_o    = ctrl.mem_to_reg;
  assign RegDst_o      = ctrl.reg_dst;
  assign RegWrite_o    = ctrl.reg_write;
  assign ALUSrcA_o     = ctrl.alu_src_a;
  assign Jal_o         = ctrl.jal;
  assign PCSource_o    = ctrl.pc_source;
  assign ALUSrcB_o     = ctrl.alu_src_b;
  assign AluOP_o       = ctrl.alu_op;
  assign instr_done_o  = ctrl.instr_done;
  assign illegal_o     = ctrl.illegal;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control. The stimulus process pushes the
// expected control vector for every cycle it drives, plus the expected
// cycle count of every completed instruction; the monitor pops and checks.
module tb_multicycle_control;

  typedef enum int {
    S_IDLE, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_EXEC, S_RWB, S_BRANCH, S_JUMP, S_JAL, S_JR, S_TRAP
  } tstate_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic [5:0] funct = 6'd0;
  logic       mem_ready = 1'b1;

  logic PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg;
  logic RegDst, RegWrite, ALUSrcA, Jal, instr_done, illegal;
  logic [1:0] PCSource, ALUSrcB, AluOP;

  multicycle_control dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .opcode_i      (opcode),
    .funct_i       (funct),
    .mem_ready_i   (mem_ready),
    .PCWrite_o     (PCWrite),
    .PCWriteCond_o (PCWriteCond),
    .IorD_o        (IorD),
    .MemRead_o     (MemRead),
    .MemWrite_o    (MemWrite),
    .IRWrite_o     (IRWrite),
    .MemtoReg_o    (MemtoReg),
    .RegDst_o      (RegDst),
    .RegWrite_o    (RegWrite),
    .ALUSrcA_o     (ALUSrcA),
    .Jal_o         (Jal),
    .PCSource_o    (PCSource),
    .ALUSrcB_o     (ALUSrcB),
    .AluOP_o       (AluOP),
    .instr_done_o  (instr_done),
    .illegal_o     (illegal)
  );

  always #5 clk = ~clk;

  // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemtoReg,RegDst,
  //  RegWrite,ALUSrcA,Jal,PCSource,ALUSrcB,AluOP,instr_done,illegal}
  logic [18:0] got;
  assign got = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                MemtoReg, RegDst, RegWrite, ALUSrcA, Jal, PCSource,
                ALUSrcB, AluOP, instr_done, illegal};

  logic [18:0] exp_q[$];
  int          cyc_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cnt = 0;

  function automatic logic [18:0] expv(input tstate_t s, input logic mr);
    logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, jal, done, ill;
    logic [1:0] pcs, asb, aop;
    {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, jal, done, ill} = '0;
    pcs = 2'b00; asb = 2'b00; aop = 2'b00;
    case (s)
      S_FETCH:  begin mrd = 1; asb = 2'b01; irw = mr; pcw = mr; end
      S_DECODE: begin asb = 2'b11; end
      S_MEMADR: begin asa = 1; asb = 2'b10; end
      S_MEMRD:  begin mrd = 1; iord = 1; end
      S_MEMWB:  begin rw = 1; m2r = 1; done = 1; end
      S_MEMWR:  begin mwr = 1; iord = 1; done = mr; end
      S_EXEC:   begin asa = 1; aop = 2'b10; end
      S_RWB:    begin rdst = 1; rw = 1; done = 1; end
      S_BRANCH: begin asa = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; done = 1; end
      S_JUMP:   begin pcw = 1; pcs = 2'b10; done = 1; end
      S_JAL:    begin pcw = 1; pcs = 2'b10; done = 1; rw = 1; jal = 1; end
      S_JR:     begin pcw = 1; pcs = 2'b11; done = 1; end
      S_TRAP:   begin ill = 1; end
      default:  ;
    endcase
    return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, jal,
            pcs, asb, aop, done, ill};
  endfunction

  // Called just after a rising edge: describes the cycle now in progress.
  task automatic step(input tstate_t s, input logic mr);
    mem_ready = mr;
    exp_q.push_back(expv(s, mr));
    @(posedge clk);
    #1;
  endtask

  task automatic instr(input logic [5:0] op, input logic [5:0] fn, input int cycles);
    opcode = op;
    funct  = fn;
    if (cycles > 0) cyc_q.push_back(cycles);
  endtask

  task automatic reset_seq();
    rst = 1'b1;
    step(S_IDLE, 1'b1);
    rst = 1'b0;
    step(S_IDLE, 1'b1);
  endtask

  // Monitor: per-cycle control vector, and per-instruction length measured
  // as non-idle cycles up to and including the instr_done cycle.
  always @(negedge clk) begin
    logic [18:0] e;
    int c;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (got !== e) begin
        n_bad++;
        $display("FAIL ctrl_vector t=%0t got=%b expected=%b", $time, got, e);
      end
    end
    if (rst) begin
      cnt = 0;
    end else begin
      if (got != '0) cnt++;
      if (instr_done === 1'b1) begin
        n_cmp++;
        if (cyc_q.size() == 0) begin
          n_bad++;
          $display("FAIL instr_cycles t=%0t got=%0d expected=none_pending", $time, cnt);
        end else begin
          c = cyc_q.pop_front();
          if (cnt != c) begin
            n_bad++;
            $display("FAIL instr_cycles t=%0t got=%0d expected=%0d", $time, cnt, c);
          end
        end
        cnt = 0;
      end
    end
  end

  initial begin
    @(posedge clk);
    #1;
    // Reset, then lw with memory always ready.
    step(S_IDLE, 1'b1);
    step(S_IDLE, 1'b0);
    rst = 1'b0;
    instr(6'b100011, 6'd0, 5);
    step(S_IDLE, 1'b1);
    step(S_FETCH, 1'b1); step(S_DECODE, 1'b1); step(S_MEMADR, 1'b0);
    step(S_MEMRD, 1'b1); step(S_MEMWB, 1'b0);

    // add, two FETCH wait cycles; mem_ready ignored in EXEC/RWB.
    instr(6'b000000, 6'b100000, 6);
    step(S_FETCH, 1'b0); step(S_FETCH, 1'b0); step(S_FETCH, 1'b1);
    step(S_DECODE, 1'b0); step(S_EXEC, 1'b0); step(S_RWB, 1'b1);

    // sw, three MEMWR wait cycles.
    instr(6'b101011, 6'd0, 7);
    step(S_FETCH, 1'b1); step(S_DECODE, 1'b1); step(S_MEMADR, 1'b1);
    step(S_MEMWR, 1'b0); step(S_MEMWR, 1'b0); step(S_MEMWR, 1'b0);
    step(S_MEMWR, 1'b1);

    // beq and j.
    instr(6'b000100, 6'd0, 3);
    step(S_FETCH, 1'b1); step(S_DECODE, 1'b1); step(S_BRANCH, 1'b0);
    instr(6'b000010, 6'd0, 3);
    step(S_FETCH, 1'b1); step(S_DECODE, 1'b1); step(S_JUMP, 1'b1);

`ifdef MC_JAL_JR_EN
    instr(6'b000000, 6'b001000, 3);
    step(S_FETCH, 1'b1); step(S_DECODE, 1'b1); step(S_JR, 1'b1);
    instr(6'b000011, 6'd0, 3);
    step(S_FETCH, 1'b1); step(S_DECODE, 1'b1); step(S_JAL, 1'b1);
`else
    instr(6'b000000, 6'b001000, 0);
    step(S_FETCH, 1'b1); step(S_DECODE, 1'b1); step(S_TRAP, 1'b1);
    step(S_TRAP, 1'b0);
    reset_seq();
    instr(6'b000011, 6'd0, 0);
    step(S_FETCH, 1'b1); step(S_DECODE, 1'b1); step(S_TRAP, 1'b1);
    step(S_TRAP, 1'b1);
    reset_seq();
`endif

    // Reset while waiting in MEMRD: outputs drop immediately.
    instr(6'b100011, 6'd0, 0);
    step(S_FETCH, 1'b1); step(S_DECODE, 1'b1); step(S_MEMADR, 1'b1);
    step(S_MEMRD, 1'b0);
    rst = 1'b1;
    #1;
    n_cmp++;
    if (got !== 19'd0) begin
      n_bad++;
      $display("FAIL async_reset_outputs got=%b expected=%b", got, 19'd0);
    end
    step(S_IDLE, 1'b1);
    rst = 1'b0;
    step(S_IDLE, 1'b1);
    instr(6'b100011, 6'd0, 5);
    step(S_FETCH, 1'b1); step(S_DECODE, 1'b1); step(S_MEMADR, 1'b1);
    step(S_MEMRD, 1'b1); step(S_MEMWB, 1'b1);

    // Unsupported opcode: TRAP is sticky regardless of mem_ready.
    instr(6'b111111, 6'd0, 0);
    step(S_FETCH, 1'b1); step(S_DECODE, 1'b1); step(S_TRAP, 1'b0);
    step(S_TRAP, 1'b1); step(S_TRAP, 1'b1);
    reset_seq();

    // Recovery after trap.
    instr(6'b000100, 6'd0, 3);
    step(S_FETCH, 1'b1); step(S_DECODE, 1'b1); step(S_BRANCH, 1'b1);
    step(S_FETCH, 1'b0);

    @(negedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL exp_queue_drained got=%0d expected=0", exp_q.size());
    end
    n_cmp++;
    if (cyc_q.size() != 0) begin
      n_bad++;
      $display("FAIL instr_done_count got=%0d_pending expected=0", cyc_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
